// File: rtl/sorter_pkg.sv
// Shared widths, word layout and FSM encoding for the nibble sorter.
// Lane 3 of a word is bits [15:12]; lane 0 is bits [3:0].
package sorter_pkg;
  localparam int NIBBLE_W = 4;
  localparam int LANES    = 4;

  typedef logic [LANES-1:0][NIBBLE_W-1:0] sort_word_t;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SORT = 2'd1,
    EMIT = 2'd2
  } sort_state_e;
endpackage

// File: rtl/sortingNetwork.sv
// Combinational 4-lane compare-exchange network.
// Output lanes are ordered so that lane 3 >= lane 2 >= lane 1 >= lane 0.
module sortingNetwork
  import sorter_pkg::*;
(
  input  sort_word_t i,
  output sort_word_t o
);

  sort_word_t a, b;

  // Returns {max, min} of two unsigned nibbles.
  function automatic logic [2*NIBBLE_W-1:0] cx(input logic [NIBBLE_W-1:0] x,
                                               input logic [NIBBLE_W-1:0] y);
    return (x >= y) ? {x, y} : {y, x};
  endfunction

  always_comb begin
    a = '0;
    b = '0;
    o = '0;
    {a[3], a[2]} = cx(i[3], i[2]);
    {a[1], a[0]} = cx(i[1], i[0]);
    {b[3], b[1]} = cx(a[3], a[1]);
    {b[2], b[0]} = cx(a[2], a[0]);
    o[3] = b[3];
    o[0] = b[0];
    {o[2], o[1]} = cx(b[2], b[1]);
  end

endmodule

// File: rtl/nibble_sort_sequencer.sv
// Serial load -> one-cycle sort -> serial emit wrapper around sortingNetwork.
// One word in flight at a time; input and output phases never overlap.
module nibble_sort_sequencer
  import sorter_pkg::*;
#(
  parameter bit ASCEND = 1'b0
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NIBBLE_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NIBBLE_W-1:0] out_data,
  output logic                out_last,
  output logic                busy
);

  sort_state_e state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  sort_word_t  stage_q, stage_d;
  sort_word_t  res_q, res_d;
  sort_word_t  sorted;
  logic [1:0]  lane;

  sortingNetwork u_net (
    .i (stage_q),
    .o (sorted)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      stage_q <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    res_d   = res_q;
    unique case (state_q)
      LOAD: begin
        if (in_valid) begin
          // First accepted nibble lands in the top lane.
          stage_d[~cnt_q] = in_data;
          cnt_d           = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = SORT;
        end
      end
      SORT: begin
        res_d   = sorted;
        state_d = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = LOAD;
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
    endcase
  end

  // Descending walks lanes 3..0, ascending walks 0..3.
  assign lane      = ASCEND ? cnt_q : ~cnt_q;
  assign in_ready  = nrst && (state_q == LOAD);
  assign out_valid = (state_q == EMIT);
  assign out_data  = out_valid ? res_q[lane] : '0;
  assign out_last  = out_valid && (cnt_q == 2'd3);
  assign busy      = (state_q != LOAD) || (cnt_q != 2'd0);

endmodule

// File: tb/tb_nibble_sort_sequencer.sv
// Directed bench: a descending and an ascending instance share all inputs,
// so every word checks both emission orders against hand-sorted values.
module tb_nibble_sort_sequencer;

  logic       clk = 1'b0;
  logic       nrst, in_valid, out_ready;
  logic [3:0] in_data;
  logic       rdy_d, ov_d, last_d, busy_d;
  logic       rdy_a, ov_a, last_a, busy_a;
  logic [3:0] od_d, od_a;

  int cyc   = 0;
  int n_err = 0;
  int n_chk = 0;
  int s1, s2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nibble_sort_sequencer #(.ASCEND(1'b0)) dut_d (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(rdy_d), .in_data(in_data),
    .out_valid(ov_d), .out_ready(out_ready), .out_data(od_d), .out_last(last_d), .busy(busy_d)
  );

  nibble_sort_sequencer #(.ASCEND(1'b1)) dut_a (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(rdy_a), .in_data(in_data),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .out_last(last_a), .busy(busy_a)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Feed four nibbles (top lane first) with optional idle cycles before each,
  // then cover the SORT cycle while offering junk on the input.
  task automatic send_word(input logic [15:0] w, input int bub, output int start);
    start = 0;
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < bub; b++) begin
        @(negedge clk); in_valid = 1'b0; in_data = 4'hF;
        @(posedge clk);
      end
      @(negedge clk); in_valid = 1'b1; in_data = w[(3-k)*4 +: 4];
      if (k == 0) begin
        start = cyc;
        chk("idle_busy", {busy_d, busy_a}, 2'b00);
      end
      chk("load_rdy", {rdy_d, rdy_a, ov_d, ov_a}, 4'b1100);
      @(posedge clk);
    end
    @(negedge clk); in_valid = 1'b1; in_data = 4'h0;
    chk("sort_cyc", {rdy_d, rdy_a, ov_d, ov_a, busy_d, busy_a}, 6'b000011);
    @(posedge clk);
  endtask

  // e holds the descending result, largest nibble in [15:12].
  task automatic recv_word(input logic [15:0] e, input int stall_at, input int stall_n);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] ed, ea;
      logic [1:0] lb;
      ed = e[(3-k)*4 +: 4];
      ea = e[k*4 +: 4];
      lb = (k == 3) ? 2'b11 : 2'b00;
      if (k == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h1;
          chk("hold", {ov_d, ov_a, rdy_d, rdy_a, od_d, od_a, last_d, last_a},
              {2'b11, 2'b00, ed, ea, lb});
          @(posedge clk);
        end
      end
      @(negedge clk); out_ready = 1'b1;
      chk("emit", {ov_d, ov_a, rdy_d, rdy_a, od_d, od_a, last_d, last_a},
          {2'b11, 2'b00, ed, ea, lb});
      @(posedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    nrst = 1'b0; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vals", {rdy_d, rdy_a, ov_d, ov_a, last_d, last_a, busy_d, busy_a, od_d, od_a}, 0);
    nrst = 1'b1;
    @(posedge clk);

    // Descending/ascending basic word, with latency and return-to-LOAD checks.
    out_ready = 1'b1;
    send_word(16'h3917, 0, s1);
    recv_word(16'h9731, -1, 0);
    @(negedge clk); in_valid = 1'b0;
    chk("post_word", {rdy_d, rdy_a, ov_d, ov_a, busy_d, busy_a, last_d, last_a}, 8'b11000000);
    @(posedge clk);

    send_word(16'hF088, 0, s1);
    recv_word(16'hF880, -1, 0);

    // Backpressure on the second output.
    send_word(16'h52E7, 0, s1);
    recv_word(16'hE752, 1, 3);

    // Input bubbles carry 0xF on the bus, which must never be latched.
    send_word(16'h4444, 1, s1);
    recv_word(16'h4444, -1, 0);

    // Reset after two nibbles.
    @(negedge clk); in_valid = 1'b1; in_data = 4'h7;
    @(posedge clk);
    @(negedge clk); in_data = 4'h8;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0; nrst = 1'b0;
    #1 chk("rst_rdy_low", {rdy_d, rdy_a}, 2'b00);
    @(posedge clk);
    @(negedge clk); nrst = 1'b1;
    #1 chk("rst_load", {ov_d, ov_a, busy_d, busy_a, last_d, last_a, od_d, od_a, rdy_d, rdy_a}, 2'b11);
    @(posedge clk);
    send_word(16'h2A5C, 0, s1);
    recv_word(16'hCA52, -1, 0);

    // Reset during EMIT after one output.
    send_word(16'h1234, 0, s1);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); nrst = 1'b0;
    @(posedge clk);
    @(negedge clk); nrst = 1'b1; in_valid = 1'b0;
    #1 chk("rst_emit", {ov_d, ov_a, busy_d, busy_a, last_d, last_a, od_d, od_a}, 0);
    @(posedge clk);
    send_word(16'h2A5C, 0, s1);
    recv_word(16'hCA52, -1, 0);

    // Back-to-back words at full rate.
    send_word(16'h1234, 0, s1);
    recv_word(16'h4321, -1, 0);
    send_word(16'h0F10, 0, s2);
    recv_word(16'hF100, -1, 0);
    chk("b2b_gap", s2 - s1, 9);

    @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;
    chk("final_idle", {ov_d, ov_a, busy_d, busy_a}, 0);
    @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
